// File: rtl/raycast_pkg.sv
// Fixed-point types and angle helpers shared by the ray-cast column scheduler.
package raycast_pkg;

  typedef logic signed [31:0] fix_t;

  typedef struct packed {
    logic is_vert;
    fix_t height;
  } line_t;

  localparam fix_t TWO_PI = 32'sh0006487E;

  // Folds an angle that is at most one turn out of range back into [0, TWO_PI).
  function automatic fix_t norm_angle(input fix_t a);
    if (a < 0) return a + TWO_PI;
    if (a >= TWO_PI) return a - TWO_PI;
    return a;
  endfunction

endpackage

// File: rtl/line_store_dp.sv
// Two-bank simple dual-port line store: one write port, one registered read port,
// each with its own bank select.
module line_store_dp #(
  parameter int  DEPTH = 640,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [32:0]   wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [32:0]   rd_data
);

  logic [32:0] mem [2][DEPTH];

  // NOTE: the array and its read register have no reset so the tools can map
  // them onto block RAM; consumers mask rd_data until a bank holds a full frame.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/ray_column_scheduler.sv
// Paces per-column ray requests to a pipelined cast engine, collects in-order
// results into the back line buffer and serves the renderer from the front one.
module ray_column_scheduler
  import raycast_pkg::*;
#(
  parameter int   H_RES           = 640,
  parameter int   MAX_OUTSTANDING = 4,
  parameter fix_t ANGLE_STEP      = 32'sh0000006B,
  parameter fix_t FOV_HALF        = 32'sh0000860A,
  localparam int  CW              = $clog2(H_RES)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          frame_in,
  input  logic          dirty_in,
  input  logic [31:0]   player_angle_in,
  output logic          req_valid_out,
  input  logic          req_ready_in,
  output logic [CW-1:0] req_col_out,
  output logic [31:0]   req_angle_out,
  input  logic          resp_valid_in,
  input  logic [CW-1:0] resp_col_in,
  input  logic [31:0]   resp_height_in,
  input  logic          resp_is_vert_in,
  input  logic [CW-1:0] rd_col_in,
  output logic [31:0]   rd_height_out,
  output logic          rd_is_vert_out,
  output logic          busy_out,
  output logic          swap_out,
  output logic          overrun_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int RW = $clog2(H_RES + 1);
  localparam logic [OW-1:0] OUT_LIMIT    = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] LAST_COL     = CW'(H_RES - 1);
  localparam logic [RW-1:0] ALL_RECEIVED = RW'(H_RES);

  logic [1:0]    state_q;
  logic [CW-1:0] col_q;
  fix_t          angle_q;
  logic [OW-1:0] outstanding_q;
  logic [RW-1:0] received_q;
  logic          first_frame_q;
  logic          front_valid_q;
  logic          bank_sel_q;
  logic          rd_valid_q;
  logic          swap_q;
  logic          overrun_q;
  logic          fire;
  logic          resp_take;
  line_t         wr_line;
  line_t         rd_line;

  assign busy_out      = (state_q == ISSUE) || (state_q == DRAIN);
  assign req_valid_out = (state_q == ISSUE) && (outstanding_q < OUT_LIMIT);
  assign fire          = req_valid_out && req_ready_in;
  // Results are only meaningful while a render is collecting them.
  assign resp_take     = resp_valid_in && busy_out;
  assign req_col_out   = col_q;
  assign req_angle_out = angle_q;
  assign swap_out      = swap_q;
  assign overrun_out   = overrun_q;
  assign wr_line       = '{is_vert: resp_is_vert_in, height: resp_height_in};

  // Front bank is bank_sel_q; the engine always fills the other one.
  line_store_dp #(.DEPTH(H_RES)) u_line_store (
    .clk_in  (clk_in),
    .wr_en   (resp_take),
    .wr_bank (~bank_sel_q),
    .wr_addr (resp_col_in),
    .wr_data (wr_line),
    .rd_bank (bank_sel_q),
    .rd_addr (rd_col_in),
    .rd_data (rd_line)
  );

  assign rd_height_out  = rd_valid_q ? rd_line.height  : '0;
  assign rd_is_vert_out = rd_valid_q ? rd_line.is_vert : 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      col_q         <= '0;
      angle_q       <= '0;
      outstanding_q <= '0;
      received_q    <= '0;
      first_frame_q <= 1'b1;
      front_valid_q <= 1'b0;
      bank_sel_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      swap_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      swap_q     <= 1'b0;
      rd_valid_q <= front_valid_q;

      case ({fire, resp_take})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - 1'b1;
        default: ;
      endcase

      if (resp_take) received_q <= received_q + 1'b1;
      if (frame_in && busy_out) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (frame_in && (dirty_in || first_frame_q)) begin
            angle_q       <= norm_angle($signed(player_angle_in) - FOV_HALF);
            col_q         <= '0;
            received_q    <= '0;
            first_frame_q <= 1'b0;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (fire) begin
            col_q   <= col_q + 1'b1;
            angle_q <= norm_angle(angle_q + ANGLE_STEP);
            if (col_q == LAST_COL) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (received_q == ALL_RECEIVED) state_q <= DONE;
        end
        default: begin
          // The swapping pulse is consumed here; the next render waits for another.
          if (frame_in) begin
            bank_sel_q    <= ~bank_sel_q;
            front_valid_q <= 1'b1;
            swap_q        <= 1'b1;
            state_q       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Randomized scoreboard bench for ray_column_scheduler with an in-order engine model.
module tb_ray_column_scheduler;

  localparam int     H_RES   = 640;
  localparam int     CW      = 10;
  localparam int     MAX_OUT = 4;
  localparam longint STEP    = 64'h6B;
  localparam longint FOVH    = 64'h860A;
  localparam longint TWOPI   = 64'h6487E;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          frame_in;
  logic          dirty_in;
  logic [31:0]   player_angle_in;
  logic          req_valid_out;
  logic          req_ready_in;
  logic [CW-1:0] req_col_out;
  logic [31:0]   req_angle_out;
  logic          resp_valid_in;
  logic [CW-1:0] resp_col_in;
  logic [31:0]   resp_height_in;
  logic          resp_is_vert_in;
  logic [CW-1:0] rd_col_in;
  logic [31:0]   rd_height_out;
  logic          rd_is_vert_out;
  logic          busy_out;
  logic          swap_out;
  logic          overrun_out;

  ray_column_scheduler dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .frame_in        (frame_in),
    .dirty_in        (dirty_in),
    .player_angle_in (player_angle_in),
    .req_valid_out   (req_valid_out),
    .req_ready_in    (req_ready_in),
    .req_col_out     (req_col_out),
    .req_angle_out   (req_angle_out),
    .resp_valid_in   (resp_valid_in),
    .resp_col_in     (resp_col_in),
    .resp_height_in  (resp_height_in),
    .resp_is_vert_in (resp_is_vert_in),
    .rd_col_in       (rd_col_in),
    .rd_height_out   (rd_height_out),
    .rd_is_vert_out  (rd_is_vert_out),
    .busy_out        (busy_out),
    .swap_out        (swap_out),
    .overrun_out     (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int col; longint angle; } req_t;
  typedef struct { int due; int col; } eng_t;

  req_t        req_exp[$];
  logic [32:0] rd_exp[$];
  eng_t        eng_q[$];

  logic [32:0] front_m [H_RES];
  logic [32:0] back_m  [H_RES];
  bit          front_valid_m = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          fires = 0;
  int          resps = 0;
  int          swap_cnt = 0;
  bit          rd_req = 1'b0;
  bit          rd_chk = 1'b0;
  bit          eng_hold = 1'b0;
  int          eng_release = 0;
  int          eng_lat = 3;
  bit          ready_rand = 1'b0;
  logic [31:0] cur_salt = '0;
  eng_t        eng_e;
  logic [31:0] eng_cv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ray angle: start of the FOV plus c whole steps, reduced modulo one turn.
  function automatic longint ray_angle(input logic [31:0] pa, input int c);
    longint a0;
    a0 = longint'(pa) - FOVH;
    if (a0 < 0) a0 += TWOPI;
    return (a0 + longint'(c) * STEP) % TWOPI;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
    rd_chk = rd_req;
  end

  // Engine: fixed latency, in order, height = col<<16 + salt.
  initial forever begin
    @(negedge clk_in);
    if (rst_n_in && req_valid_out && req_ready_in)
      eng_q.push_back('{cyc + eng_lat, int'(req_col_out)});
    @(posedge clk_in);
    #1;
    resp_valid_in = 1'b0;
    if (ready_rand) req_ready_in = ($urandom_range(0, 3) != 0);
    if (rst_n_in && eng_q.size() > 0 && eng_q[0].due <= cyc && (!eng_hold || eng_release > 0)) begin
      if (eng_hold) eng_release--;
      eng_e           = eng_q.pop_front();
      eng_cv          = 32'(eng_e.col);
      resp_valid_in   = 1'b1;
      resp_col_in     = eng_cv[CW-1:0];
      resp_height_in  = (eng_cv << 16) + cur_salt;
      resp_is_vert_in = eng_cv[0] ^ cur_salt[0];
    end
  end

  // Monitor: compares every accepted request and every read against the scoreboard.
  initial forever begin
    logic [32:0] re;
    req_t e;
    @(negedge clk_in);
    if (rst_n_in) begin
      if (req_valid_out && req_ready_in) begin
        check("outstanding_bound", 64'((fires - resps) < MAX_OUT), 64'd1);
        check("req_expected", 64'(req_exp.size() > 0), 64'd1);
        if (req_exp.size() > 0) begin
          e = req_exp.pop_front();
          check("req_col", 64'(req_col_out), 64'(e.col));
          check("req_angle", 64'(req_angle_out), e.angle);
        end
        fires++;
      end
      if (resp_valid_in && busy_out) resps++;
      if (swap_out) swap_cnt++;
      if (rd_chk) begin
        check("rd_expected", 64'(rd_exp.size() > 0), 64'd1);
        if (rd_exp.size() > 0) begin
          re = rd_exp.pop_front();
          check("rd_height", 64'(rd_height_out), 64'(re[31:0]));
          check("rd_is_vert", 64'(rd_is_vert_out), 64'(re[32]));
        end
      end
    end
  end

  task automatic read_col(input int col);
    rd_col_in = CW'(col);
    rd_req    = 1'b1;
    rd_exp.push_back(front_valid_m ? front_m[col] : 33'd0);
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic start_render(input bit dirty, input logic [31:0] pa, input logic [31:0] salt);
    logic [31:0] cv;
    cur_salt = salt;
    fires    = 0;
    resps    = 0;
    for (int c = 0; c < H_RES; c++) begin
      cv = 32'(c);
      req_exp.push_back('{c, ray_angle(pa, c)});
      back_m[c] = {cv[0] ^ salt[0], (cv << 16) + salt};
    end
    player_angle_in = pa;
    dirty_in        = dirty;
    frame_in        = 1'b1;
    tick(1);
    frame_in = 1'b0;
    dirty_in = 1'b0;
    check("busy_after_start", 64'(busy_out), 64'd1);
  endtask

  task automatic wait_fires(input int n);
    int k = 0;
    while (fires < n && k < 4000) begin tick(1); k++; end
    check("fires_reached", 64'(fires >= n), 64'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_out && k < 4000) begin tick(1); k++; end
    check("render_done", 64'(busy_out), 64'd0);
    check("all_requests_fired", 64'(fires), 64'(H_RES));
    check("no_requests_left", 64'(req_exp.size()), 64'd0);
  endtask

  task automatic frame_swap(input int col);
    rd_col_in = CW'(col);
    rd_req    = 1'b1;
    rd_exp.push_back(front_valid_m ? front_m[col] : 33'd0);
    frame_in = 1'b1;
    dirty_in = 1'($urandom_range(0, 1));
    tick(1);
    frame_in = 1'b0;
    rd_req   = 1'b0;
    check("swap_pulse", 64'(swap_out), 64'd1);
    front_m       = back_m;
    front_valid_m = 1'b1;
    tick(1);
    check("swap_one_cycle", 64'(swap_out), 64'd0);
    check("no_render_on_swap", 64'(busy_out), 64'd0);
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) read_col($urandom_range(0, H_RES - 1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap_col;
    logic [31:0] snap_angle;
    int          snap_fires;
    int          sc;

    rst_n_in        = 1'b0;
    frame_in        = 1'b0;
    dirty_in        = 1'b0;
    player_angle_in = '0;
    req_ready_in    = 1'b1;
    resp_valid_in   = 1'b0;
    resp_col_in     = '0;
    resp_height_in  = '0;
    resp_is_vert_in = 1'b0;
    rd_col_in       = '0;
    tick(3);
    check("rst_req_valid", 64'(req_valid_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_swap", 64'(swap_out), 64'd0);
    check("rst_overrun", 64'(overrun_out), 64'd0);
    check("rst_req_col", 64'(req_col_out), 64'd0);
    check("rst_req_angle", 64'(req_angle_out), 64'd0);
    check("rst_rd_height", 64'(rd_height_out), 64'd0);
    rst_n_in = 1'b1;
    tick(1);
    read_col(5);

    // Frame 1: first frame renders without dirty, 3-cycle engine, ready held high.
    start_render(1'b0, 32'h0, 32'h0);
    wait_fires(50);
    req_ready_in = 1'b0;
    tick(4);
    snap_col   = 32'(req_col_out);
    snap_angle = req_angle_out;
    snap_fires = fires;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall_valid", 64'(req_valid_out), 64'd1);
      check("stall_col", 64'(req_col_out), 64'(snap_col));
      check("stall_angle", 64'(req_angle_out), 64'(snap_angle));
    end
    check("stall_no_fire", 64'(fires), 64'(snap_fires));
    req_ready_in = 1'b1;
    wait_idle();
    check("no_swap_before_frame", 64'(swap_cnt), 64'd0);
    frame_swap(7);
    read_col(100);
    check("rd_col100_height", 64'(rd_height_out), 64'h0064_0000);
    random_reads(6);
    frame_in = 1'b1;
    tick(1);
    frame_in = 1'b0;
    tick(2);
    check("clean_frame_idle", 64'(busy_out), 64'd0);

    // Frame 2: engine stalled to probe the outstanding limit, then overrun during DRAIN.
    eng_lat  = $urandom_range(4, 8);
    eng_hold = 1'b1;
    start_render(1'b1, $urandom_range(0, 32'h6487D), $urandom);
    tick(20);
    check("limit_fires", 64'(fires), 64'(MAX_OUT));
    check("limit_valid_low", 64'(req_valid_out), 64'd0);
    eng_release = 1;
    tick(10);
    check("limit_one_more", 64'(fires), 64'(MAX_OUT + 1));
    eng_hold   = 1'b0;
    ready_rand = 1'b1;
    wait_fires(H_RES);
    ready_rand   = 1'b0;
    req_ready_in = 1'b1;
    check("drain_busy", 64'(busy_out), 64'd1);
    sc       = swap_cnt;
    frame_in = 1'b1;
    tick(1);
    frame_in = 1'b0;
    check("overrun_set", 64'(overrun_out), 64'd1);
    wait_idle();
    check("overrun_no_swap", 64'(swap_cnt), 64'(sc));
    frame_swap($urandom_range(0, H_RES - 1));
    check("overrun_sticky", 64'(overrun_out), 64'd1);
    random_reads(6);

    // Frame 3: reset while issuing, then restart from column 0.
    eng_lat = 3;
    start_render(1'b1, $urandom_range(0, 32'h6487D), $urandom);
    wait_fires(200);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_out), 64'd0);
    check("midrst_req_valid", 64'(req_valid_out), 64'd0);
    check("midrst_overrun", 64'(overrun_out), 64'd0);
    req_exp.delete();
    eng_q.delete();
    resp_valid_in = 1'b0;
    fires         = 0;
    resps         = 0;
    front_valid_m = 1'b0;
    tick(3);
    rst_n_in = 1'b1;
    tick(1);
    read_col(5);
    start_render(1'b0, $urandom_range(0, 32'h6487D), $urandom);
    ready_rand = 1'b1;
    wait_idle();
    ready_rand   = 1'b0;
    req_ready_in = 1'b1;
    frame_swap($urandom_range(0, H_RES - 1));
    random_reads(6);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
